// File: rtl/mux4_rr_arb.sv
// Four-requester valid/ready arbiter feeding one registered output stage.
// Define MUX4_RR_ARB_FIXED_PRIO_EN for fixed priority 0>1>2>3 instead of round-robin.
module mux4_rr_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_valid,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic [WIDTH-1:0] i_data_3,
  output logic [3:0]       o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_sel,
  input  logic             i_ready
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned SELW = 2;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   base_c, idx_c, gidx_c;
  logic [WIDTH-1:0]  mux_c;
  logic              load_c, any_c, xfer_c;

`ifdef MUX4_RR_ARB_FIXED_PRIO_EN
  assign base_c = '0;
`else
  logic [SELW-1:0] ptr_q, ptr_d;

  // Priority pointer moves just past the last accepted requester.
  assign ptr_d  = xfer_c ? SELW'(gidx_c + SELW'(1)) : ptr_q;
  assign base_c = ptr_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  // First valid requester in circular order starting at base_c.
  always_comb begin
    any_c  = 1'b0;
    gidx_c = base_c;
    idx_c  = base_c;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = SELW'(base_c + SELW'(i));
      if (!any_c && i_valid[idx_c]) begin
        any_c  = 1'b1;
        gidx_c = idx_c;
      end
    end
  end

  assign load_c = (state_q == ST_EMPTY) || i_ready;
  assign xfer_c = i_rst_n && load_c && any_c;

  always_comb begin
    o_ready = '0;
    if (xfer_c) o_ready[gidx_c] = 1'b1;
  end

  always_comb begin
    case (gidx_c)
      2'd0:    mux_c = i_data_0;
      2'd1:    mux_c = i_data_1;
      2'd2:    mux_c = i_data_2;
      default: mux_c = i_data_3;
    endcase
  end

  // State register for the output stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  // Refill wins over drain, giving back-to-back beats while i_ready is high.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer_c) begin
      state_d = ST_FULL;
      data_d  = mux_c;
      sel_d   = gidx_c;
    end else if ((state_q == ST_FULL) && i_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    o_valid = (state_q == ST_FULL);
    o_data  = data_q;
    o_sel   = sel_q;
  end

endmodule
